// File: rtl/gobang_pkg.sv
// rtl/gobang_pkg.sv - shared command codes, scheduler states and board defaults
package gobang_pkg;

  localparam int DEF_BOARD_SIZE = 15;

  localparam logic CMD_PLACE  = 1'b0;
  localparam logic CMD_SWITCH = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GUARD = 2'd2,
    ST_WAIT  = 2'd3
  } sched_state_t;

endpackage

// File: rtl/key_cmd_scheduler_if.sv
// rtl/key_cmd_scheduler_if.sv - command handshake between scheduler (master) and engine (slave)
interface key_cmd_if #(
  parameter int COORD_W = 4
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic               cmd_type;
  logic [COORD_W-1:0] cmd_row;
  logic [COORD_W-1:0] cmd_col;

  modport master (
    output cmd_valid, cmd_type, cmd_row, cmd_col,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_type, cmd_row, cmd_col,
    output cmd_ready
  );
endinterface

// File: rtl/cursor_axis.sv
// rtl/cursor_axis.sv - one cursor coordinate; saturates at edges, wraps when CURSOR_WRAP_EN is defined
module cursor_axis #(
  parameter int BOARD_SIZE = 15,
  parameter int COORD_W    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               inc,
  input  logic               dec,
  output logic [COORD_W-1:0] coord
);

  localparam logic [COORD_W-1:0] MAX_C = COORD_W'(BOARD_SIZE - 1);
  localparam logic [COORD_W-1:0] MID_C = COORD_W'(BOARD_SIZE / 2);

  // inc and dec are mutually exclusive: the arbiter upstream grants one move per cycle
  always_ff @(posedge clk) begin
    if (!rst) begin
      coord <= MID_C;
    end else if (inc) begin
      if (coord == MAX_C) begin
`ifdef CURSOR_WRAP_EN
        coord <= '0;
`else
        coord <= coord;
`endif
      end else begin
        coord <= coord + 1'b1;
      end
    end else if (dec) begin
      if (coord == '0) begin
`ifdef CURSOR_WRAP_EN
        coord <= MAX_C;
`else
        coord <= coord;
`endif
      end else begin
        coord <= coord - 1'b1;
      end
    end
  end

endmodule

// File: rtl/key_cmd_scheduler.sv
// rtl/key_cmd_scheduler.sv - key pulse arbiter, cursor and engine command FSM (edge wrap via CURSOR_WRAP_EN)
module key_cmd_scheduler
  import gobang_pkg::*;
#(
  parameter int BOARD_SIZE = DEF_BOARD_SIZE,
  parameter int COORD_W    = 4,
  parameter int DROP_W     = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               key_up,
  input  logic               key_down,
  input  logic               key_left,
  input  logic               key_right,
  input  logic               key_ok,
  input  logic               key_switch,
  input  logic               eng_busy,
  key_cmd_if.master          cmd,
  output logic [COORD_W-1:0] cursor_row,
  output logic [COORD_W-1:0] cursor_col,
  output logic [DROP_W-1:0]  drop_cnt
);

  sched_state_t state;

  logic cmd_req;
  logic req_type;
  logic mv_up, mv_down, mv_left, mv_right;
  logic accept_req;
  logic drop_evt;

  // Fixed priority: ok > switch > up > down > left > right
  always_comb begin
    cmd_req  = key_ok | key_switch;
    req_type = key_ok ? CMD_PLACE : CMD_SWITCH;
    mv_up    = !cmd_req && key_up;
    mv_down  = !cmd_req && !key_up && key_down;
    mv_left  = !cmd_req && !key_up && !key_down && key_left;
    mv_right = !cmd_req && !key_up && !key_down && !key_left && key_right;
  end

  assign accept_req = cmd_req && (state == ST_IDLE) && !eng_busy;
  assign drop_evt   = cmd_req && !accept_req;

  cursor_axis #(.BOARD_SIZE(BOARD_SIZE), .COORD_W(COORD_W)) u_row (
    .clk   (clk),
    .rst   (rst),
    .inc   (mv_down),
    .dec   (mv_up),
    .coord (cursor_row)
  );

  cursor_axis #(.BOARD_SIZE(BOARD_SIZE), .COORD_W(COORD_W)) u_col (
    .clk   (clk),
    .rst   (rst),
    .inc   (mv_right),
    .dec   (mv_left),
    .coord (cursor_col)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= ST_IDLE;
      cmd.cmd_valid <= 1'b0;
      cmd.cmd_type  <= CMD_PLACE;
      cmd.cmd_row   <= '0;
      cmd.cmd_col   <= '0;
      drop_cnt      <= '0;
    end else begin
      if (drop_evt && (drop_cnt != '1)) begin
        drop_cnt <= drop_cnt + 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (accept_req) begin
            cmd.cmd_type  <= req_type;
            cmd.cmd_row   <= cursor_row;
            cmd.cmd_col   <= cursor_col;
            cmd.cmd_valid <= 1'b1;
            state         <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (cmd.cmd_ready) begin
            cmd.cmd_valid <= 1'b0;
            state         <= ST_GUARD;
          end
        end
        // Gives the engine one cycle to raise eng_busy before it is sampled
        ST_GUARD: state <= ST_WAIT;
        ST_WAIT: begin
          if (!eng_busy) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_key_cmd_scheduler.sv
// tb/tb_key_cmd_scheduler.sv - directed scoreboard bench for key_cmd_scheduler
module tb_key_cmd_scheduler;
  import gobang_pkg::*;

  localparam int BS = 15;
  localparam int CW = 4;
  localparam int DW = 8;

  typedef struct {
    logic           typ;
    logic [CW-1:0]  row;
    logic [CW-1:0]  col;
  } exp_cmd_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          key_up, key_down, key_left, key_right, key_ok, key_switch;
  logic          eng_busy;
  logic [CW-1:0] cursor_row, cursor_col;
  logic [DW-1:0] drop_cnt;

  int errors = 0;
  int checks = 0;
  int exp_row = 7;
  int exp_col = 7;
  exp_cmd_t sb[$];

  key_cmd_if #(.COORD_W(CW)) bus ();

  key_cmd_scheduler #(.BOARD_SIZE(BS), .COORD_W(CW), .DROP_W(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .key_up     (key_up),
    .key_down   (key_down),
    .key_left   (key_left),
    .key_right  (key_right),
    .key_ok     (key_ok),
    .key_switch (key_switch),
    .eng_busy   (eng_busy),
    .cmd        (bus.master),
    .cursor_row (cursor_row),
    .cursor_col (cursor_col),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int step(input int v, input int d);
    int n;
    n = v + d;
`ifdef CURSOR_WRAP_EN
    if (n < 0) n = BS - 1;
    else if (n > BS - 1) n = 0;
`else
    if (n < 0) n = 0;
    else if (n > BS - 1) n = BS - 1;
`endif
    return n;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic ok, input logic sw, input logic up, input logic dn,
                       input logic lf, input logic rt);
    key_ok = ok; key_switch = sw; key_up = up; key_down = dn; key_left = lf; key_right = rt;
    tick();
    key_ok = 0; key_switch = 0; key_up = 0; key_down = 0; key_left = 0; key_right = 0;
    if (!(ok || sw)) begin
      if (up)      exp_row = step(exp_row, -1);
      else if (dn) exp_row = step(exp_row, 1);
      else if (lf) exp_col = step(exp_col, -1);
      else if (rt) exp_col = step(exp_col, 1);
    end
  endtask

  task automatic push(input logic typ, input int r, input int c);
    exp_cmd_t e;
    e.typ = typ;
    e.row = CW'(r);
    e.col = CW'(c);
    sb.push_back(e);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    exp_row = 7;
    exp_col = 7;
  endtask

  // Every handshake must match the oldest expected command
  always @(negedge clk) begin
    if (rst && bus.cmd_valid && bus.cmd_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_cmd", 32'd1, 32'd0);
      end else begin
        exp_cmd_t e;
        e = sb.pop_front();
        check("hs_type", 32'(bus.cmd_type), 32'(e.typ));
        check("hs_row",  32'(bus.cmd_row),  32'(e.row));
        check("hs_col",  32'(bus.cmd_col),  32'(e.col));
      end
    end
  end

  initial begin
    rst = 0; eng_busy = 0; bus.cmd_ready = 0;
    key_ok = 0; key_switch = 0; key_up = 0; key_down = 0; key_left = 0; key_right = 0;
    tick();
    tick();
    check("rst_row",   32'(cursor_row), 32'd7);
    check("rst_col",   32'(cursor_col), 32'd7);
    check("rst_valid", 32'(bus.cmd_valid), 32'd0);
    check("rst_type",  32'(bus.cmd_type), 32'd0);
    check("rst_crow",  32'(bus.cmd_row), 32'd0);
    check("rst_ccol",  32'(bus.cmd_col), 32'd0);
    check("rst_drop",  32'(drop_cnt), 32'd0);
    rst = 1;

    // 1: move to (5,10), place with ready held high
    bus.cmd_ready = 1;
    repeat (3) press(0, 0, 0, 0, 0, 1);
    repeat (2) press(0, 0, 1, 0, 0, 0);
    check("t1_row", 32'(cursor_row), 32'd5);
    check("t1_col", 32'(cursor_col), 32'd10);
    push(CMD_PLACE, 5, 10);
    press(1, 0, 0, 0, 0, 0);
    check("t1_valid", 32'(bus.cmd_valid), 32'd1);
    tick();
    check("t1_valid_drop", 32'(bus.cmd_valid), 32'd0);
    repeat (2) tick();

    // 2: ok beats same-cycle up
    do_reset();
    push(CMD_PLACE, 7, 7);
    press(1, 0, 1, 0, 0, 0);
    check("t2_row", 32'(cursor_row), 32'd7);
    check("t2_col", 32'(cursor_col), 32'd7);
    repeat (3) tick();

    // 3: top edge
    repeat (7) press(0, 0, 1, 0, 0, 0);
    check("t3_row0", 32'(cursor_row), 32'd0);
    press(0, 0, 1, 0, 0, 0);
`ifdef CURSOR_WRAP_EN
    check("t3_edge", 32'(cursor_row), 32'd14);
`else
    check("t3_edge", 32'(cursor_row), 32'd0);
`endif
    check("t3_edge_model", 32'(cursor_row), 32'(exp_row));

    // 4: stalled handshake; moves and rejected ok while pending
    bus.cmd_ready = 0;
    push(CMD_PLACE, exp_row, 7);
    press(1, 0, 0, 0, 0, 0);
    repeat (2) tick();
    press(0, 0, 0, 0, 1, 0);
    press(0, 0, 0, 0, 1, 0);
    tick();
    press(1, 0, 0, 0, 0, 0);
    repeat (3) tick();
    check("t4_valid", 32'(bus.cmd_valid), 32'd1);
    check("t4_crow",  32'(bus.cmd_row), 32'(exp_row));
    check("t4_ccol",  32'(bus.cmd_col), 32'd7);
    check("t4_col",   32'(cursor_col), 32'd5);
    check("t4_drop",  32'(drop_cnt), 32'd1);
    bus.cmd_ready = 1;
    tick();

    // 5: engine busy after acceptance; ok pulses dropped
    eng_busy = 1;
    bus.cmd_ready = 0;
    tick();
    for (int i = 0; i < 4; i++) begin
      press(1, 0, 0, 0, 0, 0);
      check("t5_no_valid", 32'(bus.cmd_valid), 32'd0);
      repeat (4) tick();
    end
    check("t5_drop", 32'(drop_cnt), 32'd5);
    eng_busy = 0;
    tick();
    bus.cmd_ready = 1;
    push(CMD_SWITCH, exp_row, 5);
    press(0, 1, 0, 0, 0, 0);
    check("t5_idle_valid", 32'(bus.cmd_valid), 32'd1);
    check("t5_type", 32'(bus.cmd_type), 32'(CMD_SWITCH));
    repeat (3) tick();

    // 6: saturation, then reset while a command is pending
    eng_busy = 1;
    repeat (300) press(1, 0, 0, 0, 0, 0);
    check("t6_sat", 32'(drop_cnt), 32'd255);
    eng_busy = 0;
    bus.cmd_ready = 0;
    press(1, 0, 0, 0, 0, 0);
    check("t6_valid", 32'(bus.cmd_valid), 32'd1);
    rst = 0;
    tick();
    check("t6_rst_valid", 32'(bus.cmd_valid), 32'd0);
    check("t6_rst_row",   32'(cursor_row), 32'd7);
    check("t6_rst_col",   32'(cursor_col), 32'd7);
    check("t6_rst_drop",  32'(drop_cnt), 32'd0);
    rst = 1;
    bus.cmd_ready = 1;
    repeat (3) tick();
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
